// File: rtl/hazard_pkg.sv
// Shared constants for the ID/EX hazard scoreboard: default geometry, producer latencies, bypass encoding.
package hazard_pkg;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_NUM_FWD    = 2;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = 8;

    // Bypass select value meaning "read the register file".
    localparam int FSEL_RF = 0;

    function automatic int fsel_w(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction
endpackage

// File: rtl/fwd_priority_sel.sv
// Priority encoder for one source operand: picks the youngest forwarding stage writing that register.
// Stage k maps to select k+1; no match or x0 maps to the register-file select.
module fwd_priority_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_FWD    = DEF_NUM_FWD,
    parameter int FSEL_W     = fsel_w(NUM_FWD)
) (
    input  logic [REG_ADDR_W-1:0]         i_src,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] i_fwd_rd,
    input  logic [NUM_FWD-1:0]            i_fwd_regwr,
    output logic [FSEL_W-1:0]             o_sel
);
    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        o_sel = FSEL_W'(FSEL_RF);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if ((i_src != '0) && i_fwd_regwr[k] &&
                (i_fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == i_src)) begin
                o_sel = FSEL_W'(k + 1);
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard scoreboard: per-register result countdown drives the ID stall, plus bypass selects
// and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_SRC    = 2,
    parameter int NUM_FWD    = DEF_NUM_FWD,
    parameter int MAX_LAT    = LAT_DIV,
    parameter int PERF_W     = 32,
    parameter int CNT_W      = $clog2(MAX_LAT + 1),
    parameter int FSEL_W     = fsel_w(NUM_FWD)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic                          issue_regwr,
    input  logic [CNT_W-1:0]              issue_lat,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] issue_rs,
    input  logic                          flush,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]            fwd_regwr,
    output logic [NUM_SRC*FSEL_W-1:0]     forward_sel,
    output logic                          stall,
    output logic [PERF_W-1:0]             stall_cycles
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [CNT_W-1:0]  r_cnt [NUM_REGS];
    logic [CNT_W-1:0]  w_dec [NUM_REGS];
    logic [PERF_W-1:0] r_stall_cycles;
    logic [NUM_SRC-1:0] w_src_busy;
    logic [CNT_W-1:0]  w_lat_eff;
    logic              w_fire;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_dec
        assign w_dec[r] = (r_cnt[r] == '0) ? '0 : r_cnt[r] - 1'b1;
    end

    // A count of 1 means the result lands in stage 0 next cycle and can be bypassed.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_ADDR_W-1:0] w_rs;
        assign w_rs          = issue_rs[i*REG_ADDR_W +: REG_ADDR_W];
        assign w_src_busy[i] = (w_rs != '0) && (r_cnt[w_rs] >= CNT_W'(2));

        fwd_priority_sel #(
            .REG_ADDR_W (REG_ADDR_W),
            .NUM_FWD    (NUM_FWD),
            .FSEL_W     (FSEL_W)
        ) u_fwd_sel (
            .i_src       (ex_rs[i*REG_ADDR_W +: REG_ADDR_W]),
            .i_fwd_rd    (fwd_rd),
            .i_fwd_regwr (fwd_regwr),
            .o_sel       (forward_sel[i*FSEL_W +: FSEL_W])
        );
    end

    assign stall  = issue_valid & ~flush & (|w_src_busy);
    assign w_fire = issue_valid & ~stall & ~flush & issue_regwr & (issue_rd != '0);

    always_comb begin
        w_lat_eff = issue_lat;
        if (issue_lat > CNT_W'(MAX_LAT)) begin
            w_lat_eff = CNT_W'(MAX_LAT);
        end else if (issue_lat < CNT_W'(LAT_ALU)) begin
            w_lat_eff = CNT_W'(LAT_ALU);
        end
    end

    // WAW: a re-issue never shortens an outstanding, later-completing result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_stall_cycles <= '0;
        end else begin
            r_cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_fire && (issue_rd == REG_ADDR_W'(r)) && (w_lat_eff > w_dec[r])) begin
                    r_cnt[r] <= w_lat_eff;
                end else begin
                    r_cnt[r] <= w_dec[r];
                end
            end
            if (stall && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard built with a 4-bit perf counter so saturation is reachable.
module tb_hazard_scoreboard;
    localparam int AW  = 5;
    localparam int PW  = 4;
    localparam int CW  = 4;
    localparam int FSW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           issue_valid;
    logic [AW-1:0]  issue_rd;
    logic           issue_regwr;
    logic [CW-1:0]  issue_lat;
    logic [2*AW-1:0] issue_rs;
    logic           flush;
    logic [2*AW-1:0] ex_rs;
    logic [2*AW-1:0] fwd_rd;
    logic [1:0]     fwd_regwr;
    logic [2*FSW-1:0] forward_sel;
    logic           stall;
    logic [PW-1:0]  stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.PERF_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_regwr  (issue_regwr),
        .issue_lat    (issue_lat),
        .issue_rs     (issue_rs),
        .flush        (flush),
        .ex_rs        (ex_rs),
        .fwd_rd       (fwd_rd),
        .fwd_regwr    (fwd_regwr),
        .forward_sel  (forward_sel),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic iss(input logic v, input int rd, input logic wr, input int lat,
                       input int rs0, input int rs1);
        issue_valid = v;
        issue_rd    = AW'(rd);
        issue_regwr = wr;
        issue_lat   = CW'(lat);
        issue_rs    = {AW'(rs1), AW'(rs0)};
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        ex_rs = '0;
        fwd_rd = '0;
        fwd_regwr = '0;
        iss(0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("idle_stall", 32'(stall), 0);
            chk("idle_fsel", 32'(forward_sel), 0);
            chk("idle_perf", 32'(stall_cycles), 0);
        end

        // Load-use: exactly one bubble.
        iss(1, 5, 1, 2, 0, 0);
        #1 chk("load_issue", 32'(stall), 0);
        cyc();
        iss(1, 0, 0, 1, 5, 0);
        #1 chk("load_use_bubble", 32'(stall), 1);
        cyc();
        #1 chk("load_use_go", 32'(stall), 0);
        chk("load_perf", 32'(stall_cycles), 1);
        cyc();

        // DIV dependency on rs1, flush on the third stall cycle.
        iss(1, 7, 1, 8, 0, 0);
        #1 chk("div_issue", 32'(stall), 0);
        cyc();
        iss(1, 0, 0, 1, 0, 7);
        for (int c = 1; c <= 8; c++) begin
            flush = (c == 3);
            #1 chk($sformatf("div_stall_c%0d", c), 32'(stall), 32'((c <= 7) && (c != 3)));
            cyc();
        end
        flush = 1'b0;
        chk("div_perf", 32'(stall_cycles), 7);
        iss(0, 0, 0, 0, 0, 0);

        // Bypass priority.
        fwd_rd = {AW'(7), AW'(7)};
        fwd_regwr = 2'b11;
        ex_rs = {AW'(0), AW'(7)};
        #1 chk("fwd_youngest", 32'(forward_sel), 32'h1);
        ex_rs = {AW'(7), AW'(7)};
        #1 chk("fwd_both_src", 32'(forward_sel), 32'h5);
        fwd_regwr = 2'b10;
        ex_rs = {AW'(0), AW'(7)};
        #1 chk("fwd_oldest", 32'(forward_sel), 32'h2);
        fwd_regwr = 2'b00;
        #1 chk("fwd_no_wr", 32'(forward_sel), 32'h0);
        fwd_rd = '0;
        fwd_regwr = 2'b11;
        ex_rs = '0;
        #1 chk("fwd_x0", 32'(forward_sel), 32'h0);
        fwd_regwr = 2'b00;
        cyc();

        // WAW: the short re-issue must not shorten the long one.
        iss(1, 3, 1, 8, 0, 0);
        #1 chk("waw_first", 32'(stall), 0);
        cyc();
        iss(1, 3, 1, 1, 0, 0);
        #1 chk("waw_second", 32'(stall), 0);
        cyc();
        iss(1, 0, 0, 1, 3, 0);
        for (int c = 1; c <= 7; c++) begin
            #1 chk($sformatf("waw_stall_c%0d", c), 32'(stall), 32'(c <= 6));
            cyc();
        end
        chk("waw_perf", 32'(stall_cycles), 13);

        // x0 is never tracked.
        iss(1, 0, 1, 8, 0, 0);
        cyc();
        iss(1, 0, 0, 1, 0, 0);
        #1 chk("x0_stall_a", 32'(stall), 0);
        cyc();
        #1 chk("x0_stall_b", 32'(stall), 0);
        chk("x0_perf", 32'(stall_cycles), 13);
        cyc();

        // Oversized latency clamps to MAX_LAT; perf counter saturates on the way.
        iss(1, 11, 1, 15, 0, 0);
        cyc();
        iss(1, 0, 0, 1, 11, 0);
        for (int c = 1; c <= 8; c++) begin
            #1 chk($sformatf("clamp_stall_c%0d", c), 32'(stall), 32'(c <= 7));
            chk($sformatf("sat_perf_c%0d", c), 32'(stall_cycles),
                (13 + c - 1 > 15) ? 32'd15 : 32'(13 + c - 1));
            cyc();
        end
        chk("sat_perf_end", 32'(stall_cycles), 15);

        // Reset in the middle of a stall.
        iss(1, 10, 1, 8, 0, 0);
        cyc();
        iss(1, 0, 0, 1, 10, 0);
        #1 chk("rst_pre_stall", 32'(stall), 1);
        cyc();
        rst = 1'b1;
        #1 chk("rst_asserted_stall", 32'(stall), 1);
        cyc();
        rst = 1'b0;
        #1 chk("rst_release_stall", 32'(stall), 0);
        chk("rst_release_perf", 32'(stall_cycles), 0);
        cyc();
        #1 chk("rst_after_stall", 32'(stall), 0);
        chk("rst_after_perf", 32'(stall_cycles), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
